// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per clock, signed or unsigned operands.
// Operands are reduced to magnitudes on start, and the signs are re-applied in a single fix-up cycle.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;

  logic             a_neg, b_neg, ovf_in;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_shift;
  logic             rem_ge;

  assign a_neg  = sign & dividend[WIDTH-1];
  assign b_neg  = sign & divisor[WIDTH-1];
  assign a_mag  = a_neg ? -dividend : dividend;
  assign b_mag  = b_neg ? -divisor : divisor;
  assign ovf_in = sign && (dividend == MIN_INT) && (divisor == '1);

  // The shifted partial remainder keeps one extra bit so the compare against the divisor never wraps.
  assign rem_shift = {rem_q, q_q[WIDTH-1]};
  assign rem_ge    = rem_shift >= {1'b0, b_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    q_d         = q_q;
    b_d         = b_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    dz_d        = dz_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          q_d        = a_mag;
          b_d        = b_mag;
          qneg_d     = a_neg ^ b_neg;
          rneg_d     = a_neg;
          dz_d       = (divisor == '0);
          ovf_d      = ovf_in;
          div_zero_d = 1'b0;
          cnt_d      = '0;
          rem_d      = '0;
          state_d    = ((divisor == '0) || ovf_in) ? FIX : CALC;
        end
      end
      CALC: begin
        // The subtraction result is always below the divisor, so it fits in WIDTH bits.
        if (rem_ge) begin
          rem_d = rem_shift[WIDTH-1:0] - b_q;
          q_d   = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[WIDTH-1:0];
          q_d   = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        // On divide by zero, q still holds the dividend magnitude; re-negating restores the raw dividend.
        if (dz_q) begin
          quotient_d  = '1;
          remainder_d = rneg_q ? -q_q : q_q;
          div_zero_d  = 1'b1;
        end else if (ovf_q) begin
          quotient_d  = MIN_INT;
          remainder_d = '0;
        end else begin
          quotient_d  = qneg_q ? -q_q : q_q;
          remainder_d = rneg_q ? -rem_q : rem_q;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      q_q         <= '0;
      b_q         <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      q_q         <= q_d;
      b_q         <= b_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results from an arithmetic model,
// and a monitor pops and compares them on every done pulse, including the completion edge count.
module tb_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sign = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] quotient, remainder;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           cyc;
  } exp_t;

  exp_t sb[$];

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sign(sign),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference result from plain 64-bit integer division; SV / and % truncate toward zero.
  function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int drive_cyc);
    exp_t   e;
    longint la, lb;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dz  = 1'b1;
      e.cyc = drive_cyc + 2;
    end else begin
      la    = s ? longint'($signed(a)) : longint'(a);
      lb    = s ? longint'($signed(b)) : longint'(b);
      e.q   = W'(la / lb);
      e.r   = W'(la % lb);
      e.dz  = 1'b0;
      e.cyc = drive_cyc + ((s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 2 : 34);
    end
    return e;
  endfunction

  // Called at a negedge; waits for the divider to be idle, issues one request and records its result.
  task automatic apply_stimulus(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    int guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL idle_wait: busy still %b after %0d cycles, expected 0", busy, guard);
    end
    sign     = s;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(model(s, a, b, cyc));
    @(negedge clk);
    start = 1'b0;
    check_output("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain: %0d results outstanding, expected 0", sb.size());
    end
  endtask

  logic prev_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      check_output("done_single_cycle", {31'b0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_done: done=1 at cycle %0d, expected no result pending", cyc);
      end else begin
        e = sb.pop_front();
        check_output("quotient", quotient, e.q);
        check_output("remainder", remainder, e.r);
        check_output("div_zero", {31'b0, div_zero}, {31'b0, e.dz});
        check_output("latency", W'(cyc), W'(e.cyc));
      end
    end
    prev_done = done;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time %0t exceeded, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_all_zero(input string tag);
    check_output({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check_output({tag, "_done"}, {31'b0, done}, 32'd0);
    check_output({tag, "_quotient"}, quotient, 32'd0);
    check_output({tag, "_remainder"}, remainder, 32'd0);
    check_output({tag, "_div_zero"}, {31'b0, div_zero}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int           sel;
    $display("[TB] seq_divider scoreboard bench starting");
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    apply_stimulus(1'b0, 32'd100, 32'd7);
    apply_stimulus(1'b1, -32'sd7, 32'd2);
    apply_stimulus(1'b1, 32'd7, -32'sd2);
    apply_stimulus(1'b0, 32'd5, 32'd0);
    apply_stimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    apply_stimulus(1'b0, 32'hFFFF_FFFF, 32'd1);
    apply_stimulus(1'b1, 32'h8000_0000, 32'd0);
    wait_drain();

    // A second start while busy must be ignored; then a back-to-back start lands in the done cycle.
    apply_stimulus(1'b0, 32'd100, 32'd7);
    repeat (8) @(negedge clk);
    sign     = 1'b0;
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    apply_stimulus(1'b0, 32'd9, 32'd3);
    wait_drain();

    // Reset in the middle of an operation: outputs clear at once and no done follows.
    sign     = 1'b0;
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midop_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    apply_stimulus(1'b0, 32'd50, 32'd5);
    wait_drain();

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      ra  = $urandom;
      rb  = ($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(1, 300));
      if ($urandom_range(0, 1) == 1) rb = -rb;
      if (sel == 0) rb = '0;
      if (sel == 1) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end
      apply_stimulus(1'(($urandom_range(0, 1))), ra, rb);
    end
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
